mem_req_arbiter: RTL

N-client arbiter that merges several cache-side memory request channels (icache, dcache, future DMA/accelerator ports) onto the single backing memory interface (mem_req_*, mem_req_data_*, mem_resp_*).
- Round-robin grant; grant held stable across backpressure.
- Grant locked to the writer for all write-data beats.
- Tag rewriting so responses route back to the originating client.
- Per-client outstanding-read limit.
- Sits between the cache/memory controller blocks and the top-level memory port.

---
 rtl/mem_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/mem_req_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared memory-port widths, arbiter state encoding and a clog2 helper
package mem_pkg;
  localparam int MEM_ADDR_BITS = 28;
  localparam int MEM_DATA_BITS = 128;
  localparam int MEM_TAG_BITS = 5;
  typedef enum logic [1:0] {IDLE, HOLD, WDATA} arb_state_e;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first set request at or after ptr, wrapping around
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % N);
  endfunction
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap(int'(ptr) + k)]) begin
        idx = wrap(int'(ptr) + k);
        grant = N'(1) << idx;
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin merge of client request channels onto one memory port,
// with write-burst locking, tag rewriting for response routing and per-client read limits
module mem_req_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_BITS = MEM_ADDR_BITS,
  parameter int DATA_BITS = MEM_DATA_BITS,
  parameter int TAG_BITS = MEM_TAG_BITS,
  parameter int DATA_BEATS = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int ID_BITS = clog2(NUM_CLIENTS),
  localparam int CTAG_BITS = TAG_BITS - ID_BITS,
  localparam int MASK_BITS = DATA_BITS / 8,
  localparam int OFF_BITS = clog2(DATA_BEATS),
  localparam int CNT_BITS = clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CLIENTS-1:0]           cl_req_valid,
  output logic [NUM_CLIENTS-1:0]           cl_req_ready,
  input  logic [NUM_CLIENTS-1:0]           cl_req_rw,
  input  logic [NUM_CLIENTS*ADDR_BITS-1:0] cl_req_addr,
  input  logic [NUM_CLIENTS*CTAG_BITS-1:0] cl_req_tag,
  input  logic [NUM_CLIENTS-1:0]           cl_data_valid,
  output logic [NUM_CLIENTS-1:0]           cl_data_ready,
  input  logic [NUM_CLIENTS*DATA_BITS-1:0] cl_data_bits,
  input  logic [NUM_CLIENTS*MASK_BITS-1:0] cl_data_mask,
  output logic [NUM_CLIENTS-1:0]           cl_resp_valid,
  output logic [CTAG_BITS-1:0]             cl_resp_tag,
  output logic [DATA_BITS-1:0]             cl_resp_data,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic                             mem_req_rw,
  output logic [ADDR_BITS-1:0]             mem_req_addr,
  output logic [TAG_BITS-1:0]              mem_req_tag,
  output logic                             mem_req_data_valid,
  input  logic                             mem_req_data_ready,
  output logic [DATA_BITS-1:0]             mem_req_data_bits,
  output logic [MASK_BITS-1:0]             mem_req_data_mask,
  output logic [OFF_BITS-1:0]              mem_req_data_offset,
  input  logic                             mem_resp_valid,
  input  logic [TAG_BITS-1:0]              mem_resp_tag,
  input  logic [DATA_BITS-1:0]             mem_resp_data,
  output logic                             err_unexpected_resp
);
  arb_state_e state, state_n;
  logic [ID_BITS-1:0] rr_ptr, gnt, pick_idx, cur, rid;
  logic [OFF_BITS-1:0] beat;
  logic [NUM_CLIENTS-1:0] elig, pick_oh, resp_hit, req_ready;
  logic pick_any, req_v, acc, beat_v, beat_acc, last_beat, bad_resp, err;
  rr_arbiter #(.N(NUM_CLIENTS)) u_rr (
    .req(elig),
    .ptr(rr_ptr),
    .grant(pick_oh),
    .idx(pick_idx),
    .any(pick_any)
  );
  // HOLD keeps presenting the latched client so backpressure never reshuffles the grant
  assign cur = (state == HOLD) ? gnt : pick_idx;
  assign req_v = (state == IDLE) ? pick_any : (state == HOLD) && cl_req_valid[gnt];
  assign acc = req_v && mem_req_ready;
  assign req_ready = !acc ? '0 : (state == HOLD) ? NUM_CLIENTS'(1) << gnt : pick_oh;
  assign beat_v = (state == WDATA) && cl_data_valid[gnt];
  assign beat_acc = beat_v && mem_req_data_ready;
  assign last_beat = beat == OFF_BITS'(DATA_BEATS - 1);
  assign rid = mem_resp_tag[TAG_BITS-1 -: ID_BITS];
  assign bad_resp = mem_resp_valid && !(|resp_hit);
  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_cl
    logic [CNT_BITS-1:0] cnt;
    logic inc;
    assign elig[i] = cl_req_valid[i] && (cl_req_rw[i] || cnt < CNT_BITS'(MAX_OUTSTANDING));
    assign resp_hit[i] = mem_resp_valid && rid == ID_BITS'(i) && cnt != '0;
    assign inc = acc && !cl_req_rw[cur] && cur == ID_BITS'(i);
    always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt <= '0;
      else if (inc && !resp_hit[i] && cnt < CNT_BITS'(MAX_OUTSTANDING)) cnt <= cnt + 1'b1;
      else if (resp_hit[i] && !inc) cnt <= cnt - 1'b1;
    end
  end
  always_comb begin
    state_n = state;
    if (state == WDATA) state_n = (beat_acc && last_beat) ? IDLE : WDATA;
    else state_n = acc ? (cl_req_rw[cur] ? WDATA : IDLE) : req_v ? HOLD : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      gnt <= '0;
      beat <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) rr_ptr <= (cur == ID_BITS'(NUM_CLIENTS - 1)) ? '0 : cur + 1'b1;
      if (state != WDATA) gnt <= cur;
      if (acc) beat <= '0;
      else if (beat_acc) beat <= beat + 1'b1;
      if (bad_resp) err <= 1'b1;
    end
  end
  assign cl_req_ready = reset ? '0 : req_ready;
  assign cl_data_ready = (reset || state != WDATA || !mem_req_data_ready) ? '0 : NUM_CLIENTS'(1) << gnt;
  assign cl_resp_valid = reset ? '0 : resp_hit;
  assign cl_resp_tag = reset ? '0 : mem_resp_tag[CTAG_BITS-1:0];
  assign cl_resp_data = reset ? '0 : mem_resp_data;
  assign mem_req_valid = !reset && req_v;
  assign mem_req_rw = !reset && cl_req_rw[cur];
  assign mem_req_addr = reset ? '0 : cl_req_addr[cur*ADDR_BITS +: ADDR_BITS];
  assign mem_req_tag = reset ? '0 : {cur, cl_req_tag[cur*CTAG_BITS +: CTAG_BITS]};
  assign mem_req_data_valid = !reset && beat_v;
  assign mem_req_data_bits = reset ? '0 : cl_data_bits[gnt*DATA_BITS +: DATA_BITS];
  assign mem_req_data_mask = reset ? '0 : cl_data_mask[gnt*MASK_BITS +: MASK_BITS];
  assign mem_req_data_offset = reset ? '0 : beat;
  assign err_unexpected_resp = err;
endmodule
